pipe_stage_reg: RTL and testbench

//  Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) for the 5-stage MIPS core.

---
 rtl/pipe_stage_reg.sv | 224 ++++++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic inter-stage pipeline register for the 5-stage MIPS core (IF/ID,
// ID/EX, EX/MEM, MEM/WB). It carries a control vector, a destination register
// index and NUM_WORDS data words, with valid/ready flow control on both sides.
//
// A two-entry skid buffer (main + skid) lets in_ready be a register. A stall
// from downstream therefore never forms a combinational path to upstream.
// When the output slot is empty, every output field reads as zero, so an
// empty slot presents a NOP bubble (RegWrite = MemWrite = 0).
//
// Parameters
//   DATA_W     width of each data word
//   NUM_WORDS  number of data words carried
//   CTRL_W     control vector width
//   DEST_W     destination register index width
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   flush      in   discard all held entries and the current input
//   in_valid   in   upstream presents a valid instruction
//   in_ready   out  stage can accept (registered)
//   in_ctrl    in   control bits
//   in_dest    in   destination register
//   in_data    in   data words; word k = [k*DATA_W +: DATA_W]
//   out_valid  out  output slot holds a valid instruction
//   out_ready  in   downstream accepts
//   out_ctrl   out  control bits, 0 when out_valid = 0
//   out_dest   out  destination register, 0 when out_valid = 0
//   out_data   out  data words, 0 when out_valid = 0
//   occupancy  out  number of held entries (0, 1 or 2)
//   stall_count out [15:0] saturating count of cycles with out_valid=1 and
//                   out_ready=0; present only when PIPE_STAGE_STATS_EN is
//                   defined. Cleared by reset, kept across flush.
//
// Build option
//   PIPE_STAGE_STATS_EN  adds the stall_count port and its counter.
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 3,
  parameter int CTRL_W    = 12,
  parameter int DEST_W    = 5
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CTRL_W-1:0]           in_ctrl,
  input  logic [DEST_W-1:0]           in_dest,
  input  logic [NUM_WORDS*DATA_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [DEST_W-1:0]           out_dest,
  output logic [NUM_WORDS*DATA_W-1:0] out_data,
  output logic [1:0]                  occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]                 stall_count
`endif
);

  // Occupancy doubles as the state encoding, so the occupancy port is the
  // state register itself.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,  // nothing held
    S_HALF  = 2'd1,  // main valid
    S_FULL  = 2'd2   // main and skid valid
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic                          r_in_ready;

  logic [CTRL_W-1:0]             r_main_ctrl;
  logic [DEST_W-1:0]             r_main_dest;
  logic [NUM_WORDS*DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]             r_skid_ctrl;
  logic [DEST_W-1:0]             r_skid_dest;
  logic [NUM_WORDS*DATA_W-1:0]   r_skid_data;

  logic                          w_main_valid;
  logic                          w_accept;
  logic                          w_emit;
  logic                          w_main_from_in;
  logic                          w_main_from_skid;
  logic                          w_skid_from_in;

  assign w_main_valid = (r_state != S_EMPTY);
  // in_ready is 0 in FULL, so an accept can only happen in EMPTY or HALF.
  assign w_accept     = in_valid & r_in_ready;
  assign w_emit       = w_main_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Next-state and payload-steering decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    w_state_next     = r_state;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;

    unique case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_next   = S_HALF;
          w_main_from_in = 1'b1;
        end
      end
      S_HALF: begin
        if (w_accept && w_emit) begin
          // Main leaves and is replaced by the incoming entry in the same cycle.
          w_main_from_in = 1'b1;
        end else if (w_accept) begin
          // Main is stalled; park the new entry behind it.
          w_state_next   = S_FULL;
          w_skid_from_in = 1'b1;
        end else if (w_emit) begin
          w_state_next   = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_emit) begin
          w_state_next     = S_HALF;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_next = S_EMPTY;
      end
    endcase

    // Flush drops everything held plus whatever is being accepted right now.
    // An emit in this cycle has already been seen downstream and completes.
    if (flush) begin
      w_state_next     = S_EMPTY;
      w_main_from_in   = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_from_in   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered in_ready
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values of the others, whatever the order.
    if (reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != S_FULL);
    end
  end

  // ---------------------------------------------------------------------------
  // Payload registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: the payload registers are cleared on reset even though the output
    // gating already hides them; this keeps them from holding stale values
    // that would be visible in debug or in a downstream bypass.
    if (reset) begin
      r_main_ctrl <= '0;
      r_main_dest <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_dest <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_main_from_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_dest <= in_dest;
        r_main_data <= in_data;
      end else if (w_main_from_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_dest <= r_skid_dest;
        r_main_data <= r_skid_data;
      end

      if (w_skid_from_in) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_dest <= in_dest;
        r_skid_data <= in_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: an empty slot reads as an all-zero NOP
  // ---------------------------------------------------------------------------
  assign in_ready  = r_in_ready;
  assign out_valid = w_main_valid;
  assign out_ctrl  = w_main_valid ? r_main_ctrl : '0;
  assign out_dest  = w_main_valid ? r_main_dest : '0;
  assign out_data  = w_main_valid ? r_main_data : '0;
  assign occupancy = r_state;

`ifdef PIPE_STAGE_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating downstream-stall counter
  // ---------------------------------------------------------------------------
  logic [15:0] r_stall_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_main_valid && !out_ready && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg. A queue-based model of the stage
// (at most two held entries, strict FIFO order) is updated at every rising
// edge from the sampled inputs; a compare process checks every DUT output
// against it on each falling edge. Directed tests add literal expectations.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DATA_W    = 32;
  localparam int NUM_WORDS = 3;
  localparam int CTRL_W    = 12;
  localparam int DEST_W    = 5;
  localparam int DW        = NUM_WORDS * DATA_W;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DEST_W-1:0] dest;
    logic [DW-1:0]     data;
  } ent_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DEST_W-1:0] in_dest;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DEST_W-1:0] out_dest;
  logic [DW-1:0]     out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0]       stall_count;
`endif

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .NUM_WORDS(NUM_WORDS),
    .CTRL_W   (CTRL_W),
    .DEST_W   (DEST_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_dest  (in_dest),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_dest (out_dest),
    .out_data (out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a FIFO of at most two entries
  // ---------------------------------------------------------------------------
  ent_t  m_q[$];
  ent_t  emit_log[$];
  bit    m_ready       = 1'b0;
  bit    m_known       = 1'b0;
  bit    m_last_accept = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] m_stall = '0;
`endif

  always @(posedge clock) begin
    bit acc;
    bit emit;
    if (reset) begin
      m_q.delete();
      m_ready       = 1'b0;
      m_known       = 1'b1;
      m_last_accept = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
      m_stall       = '0;
`endif
    end else if (m_known) begin
      acc  = in_valid && m_ready;
      emit = (m_q.size() > 0) && out_ready;
`ifdef PIPE_STAGE_STATS_EN
      if ((m_q.size() > 0) && !out_ready && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
`endif
      if (emit) emit_log.push_back(m_q.pop_front());
      if (flush) begin
        m_q.delete();
        acc = 1'b0;
      end else if (acc) begin
        m_q.push_back('{ctrl: in_ctrl, dest: in_dest, data: in_data});
      end
      if (m_q.size() > 2) begin
        n_vec++;
        n_fail++;
        $display("FAIL model_overflow: size %0d, limit 2", m_q.size());
      end
      m_ready       = (m_q.size() != 2);
      m_last_accept = acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin
    ent_t exp_e;
    if (m_known) begin
      exp_e = (m_q.size() > 0) ? m_q[0] : '0;
      check("occupancy", 128'(occupancy), 128'(m_q.size()));
      check("out_valid", 128'(out_valid), 128'(m_q.size() > 0));
      check("in_ready",  128'(in_ready),  128'(m_ready));
      check("out_ctrl",  128'(out_ctrl),  128'(exp_e.ctrl));
      check("out_dest",  128'(out_dest),  128'(exp_e.dest));
      check("out_data",  128'(out_data),  128'(exp_e.data));
`ifdef PIPE_STAGE_STATS_EN
      check("stall_count", 128'(stall_count), 128'(m_stall));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic set_in(input logic v, input logic [CTRL_W-1:0] c,
                        input logic [DEST_W-1:0] d, input logic [DW-1:0] x);
    in_valid = v;
    in_ctrl  = c;
    in_dest  = d;
    in_data  = x;
  endtask

  // Hold one entry on the input until the model reports it accepted.
  task automatic push(input logic [CTRL_W-1:0] c, input logic [DEST_W-1:0] d,
                      input logic [DW-1:0] x, input bit toggle_ready);
    int budget;
    budget = 0;
    set_in(1'b1, c, d, x);
    do begin
      if (toggle_ready) out_ready = ~out_ready;
      step();
      budget++;
    end while (!m_last_accept && budget < 50);
    if (!m_last_accept) check("push_timeout", 128'(budget), 128'(0));
    set_in(1'b0, '0, '0, '0);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    out_ready = 1'b1;
    while (m_q.size() > 0 && budget < 20) begin
      step();
      budget++;
    end
    if (m_q.size() > 0) check("drain_timeout", 128'(m_q.size()), 128'(0));
  endtask

  localparam logic [DW-1:0] D1 = {32'h3, 32'h2, 32'h1};
  localparam logic [DW-1:0] DA = {32'hA2, 32'hA1, 32'hA0};
  localparam logic [DW-1:0] DB = {32'hB2, 32'hB1, 32'hB0};
  localparam logic [DW-1:0] DC = {32'hC2, 32'hC1, 32'hC0};

  initial begin
    int base;
    int n_c;
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, '0, '0, '0);
    step();
    step();
    @(negedge clock);
    check("reset_in_ready", 128'(in_ready), 128'(0));
    check("reset_occ",      128'(occupancy), 128'(0));
    reset = 1'b0;
    step();

    // 1. single transfer, one-cycle latency
    check("t1_ready_after_reset", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    set_in(1'b1, 12'h0A5, 5'd9, D1);
    step();
    set_in(1'b0, '0, '0, '0);
    @(negedge clock);
    check("t1_valid", 128'(out_valid), 128'(1));
    check("t1_ctrl",  128'(out_ctrl),  128'(12'h0A5));
    check("t1_dest",  128'(out_dest),  128'(5'd9));
    check("t1_data",  128'(out_data),  128'(D1));
    check("t1_occ",   128'(occupancy), 128'(1));
    step();

    // 2. fill behind a stall, then drain
    out_ready = 1'b0;
    push(12'h111, 5'd1, DA, 1'b0);
    push(12'h222, 5'd2, DB, 1'b0);
    @(negedge clock);
    check("t2_occ",      128'(occupancy), 128'(2));
    check("t2_in_ready", 128'(in_ready),  128'(0));
    check("t2_data_a",   128'(out_data),  128'(DA));
    out_ready = 1'b1;
    step();
    @(negedge clock);
    check("t2_data_b",   128'(out_data),  128'(DB));
    check("t2_ready_up", 128'(in_ready),  128'(1));
    step();
    @(negedge clock);
    check("t2_empty",    128'(out_valid), 128'(0));

    // 3. 100-word stream with out_ready toggling
    base = emit_log.size();
    for (int i = 0; i < 100; i++) begin
      push(CTRL_W'(i), DEST_W'(i), {32'(i + 2000), 32'(i + 1000), 32'(i)}, 1'b1);
    end
    drain();
    check("t3_count", 128'(emit_log.size() - base), 128'(100));
    for (int i = 0; i < 100 && (base + i) < emit_log.size(); i++) begin
      check("t3_order", 128'(emit_log[base + i].data[31:0]), 128'(i));
    end

    // 4. flush from FULL with a valid input pending
    out_ready = 1'b0;
    push(12'h333, 5'd3, DA, 1'b0);
    push(12'h444, 5'd4, DB, 1'b0);
    set_in(1'b1, 12'h555, 5'd5, DC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_in(1'b0, '0, '0, '0);
    @(negedge clock);
    check("t4_valid",    128'(out_valid), 128'(0));
    check("t4_ctrl",     128'(out_ctrl),  128'(0));
    check("t4_data",     128'(out_data),  128'(0));
    check("t4_occ",      128'(occupancy), 128'(0));
    check("t4_in_ready", 128'(in_ready),  128'(1));
    // flush while emitting: the head still goes out, the rest is dropped
    out_ready = 1'b1;
    push(12'h666, 5'd6, DA, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drain();
    n_c = 0;
    foreach (emit_log[i]) if (emit_log[i].data == DC) n_c++;
    check("t4_c_never_out", 128'(n_c), 128'(0));

    // 5. reset mid-stream at occupancy 2
    out_ready = 1'b0;
    push(12'h777, 5'd7, DA, 1'b0);
    push(12'h888, 5'd8, DB, 1'b0);
    reset = 1'b1;
    step();
    @(negedge clock);
    check("t5_valid",    128'(out_valid), 128'(0));
    check("t5_data",     128'(out_data),  128'(0));
    check("t5_occ",      128'(occupancy), 128'(0));
    check("t5_in_ready", 128'(in_ready),  128'(0));
    reset = 1'b0;
    step();
    @(negedge clock);
    check("t5_ready_after", 128'(in_ready), 128'(1));

`ifdef PIPE_STAGE_STATS_EN
    // 6. stall counter: 7 stall cycles, then saturation
    push(12'h999, 5'd10, DA, 1'b0);
    for (int i = 0; i < 7; i++) step();
    @(negedge clock);
    check("t6_stall7", 128'(stall_count), 128'(7));
    step();
    force dut.r_stall_count = 16'hFFFE;
    m_stall = 16'hFFFE;
    #1;
    release dut.r_stall_count;
    for (int i = 0; i < 3; i++) step();
    @(negedge clock);
    check("t6_saturate", 128'(stall_count), 128'(16'hFFFF));
    drain();
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
